// File: rtl/mem_pkg.sv
// Shared types and constants for the line-wide main memory: word width, FSM states,
// the bring-up boot image and the line-alignment helper.
package mem_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  // ADDI/LD/ADD/COMPLT/branch bring-up program, loaded at mem[0..BOOT_WORDS-1]
  localparam int BOOT_WORDS = 8;
  localparam logic [WORD_WIDTH-1:0] BOOT_IMAGE [BOOT_WORDS] = '{
    32'h08010080,
    32'h081F0000,
    32'h08050000,
    32'h08020000,
    32'h0C221800,
    32'h14232000,
    32'h1C00FFF0,
    32'h00000000
  };

  // Word index of the first word of the line containing byte address addr.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int line_words);
    return (addr >> 2) & ~(64'(line_words) - 64'd1);
  endfunction

endpackage

// File: rtl/line_main_memory_if.sv
// Request/response channel bundle between a cache-side master and the main memory.
interface line_main_memory_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
);

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_we;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [LINE_WORDS*WORD_WIDTH-1:0] req_wdata;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [LINE_WORDS*WORD_WIDTH-1:0] resp_rdata;
  logic                             resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_word_array.sv
// Word storage split into LINE_WORDS banks so a whole aligned line is written or read per cycle.
// With MAIN_MEM_BOOT_IMAGE_EN defined, boot_i writes BOOT_IMAGE into the lowest words.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1048576,
  parameter int LINE_WORDS  = 4,
  localparam int BANK_AW    = (DEPTH_WORDS > LINE_WORDS) ? $clog2(DEPTH_WORDS / LINE_WORDS) : 1
) (
  input  logic                             clk,
`ifdef MAIN_MEM_BOOT_IMAGE_EN
  input  logic                             boot_i,
`endif
  input  logic                             we_i,
  input  logic                             re_i,
  input  logic [BANK_AW-1:0]               idx_i,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] wdata_i,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] rdata_o
);

  localparam int BANK_DEPTH = DEPTH_WORDS / LINE_WORDS;

  // Bank gi holds the word at offset gi within each line; offset 0 sits in the top bits.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
    logic [WORD_WIDTH-1:0] bank_q [BANK_DEPTH];
    logic [WORD_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i) begin
        bank_q[idx_i] <= wdata_i[(LINE_WORDS-1-gi)*WORD_WIDTH +: WORD_WIDTH];
      end
`ifdef MAIN_MEM_BOOT_IMAGE_EN
      if (boot_i) begin
        for (int k = gi; k < BOOT_WORDS; k += LINE_WORDS) begin
          bank_q[BANK_AW'(k / LINE_WORDS)] <= BOOT_IMAGE[k];
        end
      end
`endif
      if (re_i) begin
        rd_q <= bank_q[idx_i];
      end
    end

    assign rdata_o[(LINE_WORDS-1-gi)*WORD_WIDTH +: WORD_WIDTH] = rd_q;
  end

endmodule

// File: rtl/line_main_memory.sv
// Fixed-latency main memory serving whole cache lines over valid/ready request/response channels.
// Optional reset-time boot image load is enabled by defining MAIN_MEM_BOOT_IMAGE_EN.
module line_main_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1048576,
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 5
) (
  input logic               clk,
  input logic               reset,
  line_main_memory_if.slave bus
);

  localparam int LINE_BITS = LINE_WORDS * WORD_WIDTH;
  localparam int LW_LOG2   = $clog2(LINE_WORDS);
  localparam int BANK_AW   = (DEPTH_WORDS > LINE_WORDS) ? $clog2(DEPTH_WORDS / LINE_WORDS) : 1;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q;
  logic                 err_q;
  logic [BANK_AW-1:0]   idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] arr_rdata;
  logic                 accept;
  logic                 mem_we;
  logic                 mem_re;
  logic [63:0]          req_base;
  logic                 req_oor;

  assign req_base = line_base(64'(bus.req_addr), LINE_WORDS);
  assign req_oor  = (req_base + 64'(LINE_WORDS)) > 64'(DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          mem_we  = we_q && !err_q;
          mem_re  = !we_q && !err_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset wins over everything, so an in-flight write never commits.
    if (reset) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      accept  = 1'b0;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    if (reset) begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      err_q   <= req_oor;
      idx_q   <= BANK_AW'(req_base >> LW_LOG2);
      wdata_q <= bus.req_wdata;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk    (clk),
`ifdef MAIN_MEM_BOOT_IMAGE_EN
    .boot_i (reset),
`endif
    .we_i   (mem_we),
    .re_i   (mem_re),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  // The array read register only updates on a read access, so the line stays stable through RESP.
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = (state_q == ST_RESP) && err_q;
  assign bus.resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_line_main_memory.sv
// Bench for line_main_memory: three instances (LATENCY 5, 1, 8), directed table, corner sequences,
// and randomized traffic against a line-level reference model.
module tb_line_main_memory;

  localparam int N_DUT = 3;
  localparam logic [127:0] BOOT_LINE = {32'h08010080, 32'h081F0000, 32'h08050000, 32'h08020000};
  localparam logic [127:0] LINE_A    = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [127:0] PRIOR     = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] NEWDATA   = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] TOPLINE   = 128'h76543210_FEDCBA98_13579BDF_2468ACE0;
  localparam logic [127:0] LINE_B    = 128'h0BADF00D_FACEFEED_C0FFEE00_BEEFCAFE;
  localparam int POOL_LINES = 16;
  localparam logic [31:0] POOL_BASE = 32'h0000_8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N_DUT-1:0] reset, req_valid, req_we, resp_ready;
  logic [N_DUT-1:0] req_ready, resp_valid, resp_err;
  logic [31:0]      req_addr   [N_DUT];
  logic [127:0]     req_wdata  [N_DUT];
  logic [127:0]     resp_rdata [N_DUT];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    line_main_memory_if #(.ADDR_WIDTH(32), .LINE_WORDS(4)) bus_if ();

    assign bus_if.req_valid  = req_valid[gi];
    assign bus_if.req_we     = req_we[gi];
    assign bus_if.req_addr   = req_addr[gi];
    assign bus_if.req_wdata  = req_wdata[gi];
    assign bus_if.resp_ready = resp_ready[gi];
    assign req_ready[gi]     = bus_if.req_ready;
    assign resp_valid[gi]    = bus_if.resp_valid;
    assign resp_err[gi]      = bus_if.resp_err;
    assign resp_rdata[gi]    = bus_if.resp_rdata;

    line_main_memory #(
      .ADDR_WIDTH (32),
      .DEPTH_WORDS(1048576),
      .LINE_WORDS (4),
      .LATENCY    (gi == 0 ? 5 : (gi == 1 ? 1 : 8))
    ) dut (
      .clk  (clk),
      .reset(reset[gi]),
      .bus  (bus_if)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 5 : ((d == 1) ? 1 : 8);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_req_ready", 128'(req_ready[d]), 128'(1));
    chk("rst_resp_valid", 128'(resp_valid[d]), 128'(0));
    chk("rst_resp_rdata", resp_rdata[d], '0);
    chk("rst_resp_err", 128'(resp_err[d]), 128'(0));
  endtask

  // Presents a request and returns #1 after the edge that accepted it.
  task automatic issue(input int d, input bit we, input logic [31:0] addr, input logic [127:0] wdata);
    int cyc = 0;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    while (!req_ready[d] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 50) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got=0 want=1 after %0d cycles", cyc);
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  // Counts edges from acceptance until resp_valid is seen.
  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    while (!resp_valid[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) begin
      checks++;
      errors++;
      $display("FAIL resp_valid_timeout: got=0 want=1 after %0d cycles", lat);
    end
  endtask

  task automatic ack(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  task automatic xact(input int d, input bit we, input logic [31:0] addr, input logic [127:0] wdata,
                      input logic [127:0] exp_rdata, input bit exp_err);
    int lat;
    logic [127:0] rd;
    logic er;
    issue(d, we, addr, wdata);
    wait_resp(d, lat);
    rd = resp_rdata[d];
    er = resp_err[d];
    $display("dut%0d %s addr=%h lat=%0d rdata=%h err=%0d", d, we ? "WR" : "RD", addr, lat, rd, er);
    chk("latency", 128'(lat), 128'(lat_of(d)));
    chk("rdata", rd, exp_rdata);
    chk("err", 128'(er), 128'(exp_err));
    ack(d);
  endtask

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    bit           exp_err;
  } vec_t;

  vec_t vecs [11];
  logic [127:0] model [POOL_LINES];

  initial begin
    int lat;
    int idx;
    bit we;
    logic [31:0] addr;
    logic [127:0] data;

    vecs[0]  = '{0, 32'h0000_0000, '0,      BOOT_LINE, 0};
    vecs[1]  = '{1, 32'h0000_0100, LINE_A,  '0,        0};
    vecs[2]  = '{0, 32'h0000_010C, '0,      LINE_A,    0};
    vecs[3]  = '{0, 32'h0000_0104, '0,      LINE_A,    0};
    vecs[4]  = '{1, 32'h0000_0200, PRIOR,   '0,        0};
    vecs[5]  = '{0, 32'h0000_0200, '0,      PRIOR,     0};
    vecs[6]  = '{0, 32'h0040_0000, '0,      '0,        1};
    vecs[7]  = '{1, 32'h003F_FFF0, TOPLINE, '0,        0};
    vecs[8]  = '{0, 32'h003F_FFFF, '0,      TOPLINE,   0};
    vecs[9]  = '{1, 32'h0040_0010, NEWDATA, '0,        1};
    vecs[10] = '{0, 32'hFFFF_FFF0, '0,      '0,        1};

    reset = '1;
    req_valid = '0;
    req_we = '0;
    resp_ready = '0;
    for (int d = 0; d < N_DUT; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = '0;
    for (int d = 0; d < N_DUT; d++) chk_reset_outputs(d);

`ifndef MAIN_MEM_BOOT_IMAGE_EN
    xact(0, 1, 32'h0000_0000, BOOT_LINE, '0, 0);
`endif

    for (int i = 0; i < 11; i++) begin
      xact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Stalled response: outputs hold, further requests ignored.
    issue(0, 0, 32'h0000_0100, '0);
    wait_resp(0, lat);
    $display("dut0 RD addr=00000100 lat=%0d rdata=%h err=%0d (stalled)", lat, resp_rdata[0], resp_err[0]);
    chk("stall_latency", 128'(lat), 128'(5));
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_wdata[0] = ~LINE_A;
    for (int i = 0; i < 7; i++) begin
      chk("stall_resp_valid", 128'(resp_valid[0]), 128'(1));
      chk("stall_rdata", resp_rdata[0], LINE_A);
      chk("stall_req_ready", 128'(req_ready[0]), 128'(0));
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    ack(0);
    chk("post_ack_req_ready", 128'(req_ready[0]), 128'(1));
    chk("post_ack_resp_valid", 128'(resp_valid[0]), 128'(0));
    xact(0, 0, 32'h0000_0100, '0, LINE_A, 0);

    // Reset two cycles into a write: aborted, old contents remain.
    issue(0, 1, 32'h0000_0200, NEWDATA);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    $display("dut0 WR addr=00000200 aborted by reset");
    chk_reset_outputs(0);
    xact(0, 0, 32'h0000_0200, '0, PRIOR, 0);

    // Reset while a committed write waits in RESP: data persists.
    issue(0, 1, 32'h0000_0300, LINE_B);
    wait_resp(0, lat);
    $display("dut0 WR addr=00000300 lat=%0d reset in response", lat);
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    chk_reset_outputs(0);
    xact(0, 0, 32'h0000_0300, '0, LINE_B, 0);

    // Random back-to-back traffic on LATENCY=1 and LATENCY=8 instances.
    for (int d = 1; d < N_DUT; d++) begin
      for (int i = 0; i < POOL_LINES; i++) begin
        model[i] = {$urandom, $urandom, $urandom, $urandom};
        xact(d, 1, POOL_BASE + 32'(i * 16), model[i], '0, 0);
      end
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          we   = 1'($urandom_range(0, 1));
          addr = 32'h0040_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
          data = {$urandom, $urandom, $urandom, $urandom};
          xact(d, we, addr, data, '0, 1);
        end else begin
          idx  = $urandom_range(0, POOL_LINES - 1);
          we   = 1'($urandom_range(0, 1));
          addr = POOL_BASE + 32'(idx * 16) + 32'($urandom_range(0, 15));
          data = {$urandom, $urandom, $urandom, $urandom};
          if (we) begin
            model[idx] = data;
            xact(d, 1, addr, data, '0, 0);
          end else begin
            xact(d, 0, addr, '0, model[idx], 0);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_main_memory.md
Name: line_main_memory

Overview:
Clocked, parametrised main memory that replaces the combinational word-array memory. It serves whole cache lines of LINE_WORDS 32-bit words over a valid/ready request channel and a valid/ready response channel. Access latency is fixed and programmable, so the instruction and data caches see realistic miss timing. It sits below the caches in the memory hierarchy, as the sole backing store of the processor.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr
DEPTH_WORDS, 1048576, number of 32-bit words in the array (power of two)
LINE_WORDS, 4, words per line transfer (power of two, >=1)
LATENCY, 5, cycles from request acceptance to resp_valid (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = line write, 0 = line read
req_addr  in  ADDR_WIDTH  byte address; low log2(LINE_WORDS*4) bits ignored
req_wdata  in  LINE_WORDS*32  write line
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  LINE_WORDS*32  read line (zero for writes)
resp_err  out  1  address out of range

Behaviour:
- Reset is synchronous and active-high. It forces state IDLE and latency counter 0. Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Array contents are not cleared by reset, except as described under Optional Feature.
- Line packing: word at the lowest address goes in the most significant 32 bits, i.e. resp_rdata[LINE_WORDS*32-1 -: 32] = mem[base].
- Word index: base = req_addr[ADDR_WIDTH-1:2] with the low log2(LINE_WORDS) bits forced to 0.
- State machine IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we, addr and wdata, load the counter with LATENCY-1, and go to BUSY. req_ready drops the next cycle.
  - BUSY: req_ready=0. Counter decrements each cycle. When the counter is 0, perform the access:
    - Write: commit all LINE_WORDS words.
    - Read: capture the line into resp_rdata.
    - Then go to RESP.
  - The RESP state is entered at acceptance cycle + LATENCY, and resp_valid=1 from that cycle.
  - RESP: resp_valid, resp_rdata and resp_err are held stable until resp_valid&&resp_ready. On that handshake, clear resp_valid and return to IDLE. req_ready is 1 again the following cycle, so there is one idle cycle minimum between accepted requests.
- Out of range: if base+LINE_WORDS > DEPTH_WORDS, the write is discarded and read data is 0. resp_err=1 for that response.
- Writes also return a response: resp_rdata=0, resp_err as above.
- Reset during BUSY or RESP: the transaction is aborted and a pending write is NOT committed. A write already committed in RESP persists.
- No request queuing. req_* are ignored while not in IDLE.
- Read-after-write ordering is guaranteed by serialisation.

Optional Feature:
- Macro: MAIN_MEM_BOOT_IMAGE_EN.
- When defined, every reset cycle also writes the package constant BOOT_IMAGE[0..BOOT_WORDS-1] into mem[0..BOOT_WORDS-1]. This loads the ADDI/LD/ADD/COMPLT/branch bring-up program; all other words are untouched.
- When undefined, reset does not modify the array, and the image must be loaded by testbench backdoor.

Decomposition:
- Shared package mem_pkg holds:
  - WORD_WIDTH=32
  - state enum {ST_IDLE, ST_BUSY, ST_RESP}
  - BOOT_WORDS and the BOOT_IMAGE constant array
  - function line_base(addr) returning the aligned word index
- One natural sub-module: mem_word_array. It is a synchronous-write, line-wide-read storage array with a DEPTH_WORDS parameter, which keeps the FSM separate from the storage.

Test Plan:
- Reset then read addr 0x0 with LATENCY=5, boot image enabled.
  - resp_valid rises exactly 5 cycles after acceptance.
  - resp_rdata = {0x08010080, 0x081F0000, 0x08050000, 0x08020000}, resp_err=0.
- Write addr 0x100 with {0x11111111, 0x22222222, 0x33333333, 0x44444444}, then read addr 0x10C.
  - The read returns the same line (low bits ignored).
  - The write response has rdata=0.
- Hold resp_ready=0 for 7 cycles on a read.
  - resp_valid and resp_rdata stay stable.
  - req_ready=0 throughout and a second req_valid is ignored.
  - After the handshake, req_ready=1 one cycle later.
- Assert reset 2 cycles into a write to addr 0x200.
  - Outputs go to reset values.
  - A subsequent read of 0x200 returns the prior contents, not the write data.
- Read addr 0x00400000 with DEPTH_WORDS=1048576: resp_err=1, resp_rdata=0.
- Run back-to-back random reads and writes against a reference model with LATENCY=1 and LATENCY=8.
  - All data matches.
  - Latency is exact on every transaction.
